// File: rtl/rx_page_ctrl_pkg.sv
// Shared constants for the RX page scheduler: default page flags, statistics
// counter width and the largest supported page index width.
package rx_page_ctrl_pkg;
  localparam logic [7:0] FLAG_OK    = 8'h00;
  localparam int         STAT_W     = 8;
  localparam int         PAGE_W_MAX = 4;
endpackage

// File: rtl/rx_page_ctrl_sat_cnt.sv
// Saturating event counter for statistics: increments on inc, sticks at all-ones,
// and clr forces zero even when it coincides with an increment.
module sat_cnt
  import rx_page_ctrl_pkg::*;
#(
  parameter int W = STAT_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != {W{1'b1}}))
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/rx_page_ctrl.sv
// Receive page scheduler: hands the byte receiver a write page, queues filled pages
// for the CPU in FIFO order; new wr_page visible one cycle after rx_switch.
module rx_page_ctrl
  import rx_page_ctrl_pkg::*;
#(
  parameter int PAGE_W = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx_switch,
  input  logic [7:0]        rx_flags,
  input  logic              rx_error,
  output logic [PAGE_W-1:0] wr_page,
  output logic [PAGE_W-1:0] rd_page,
  output logic [7:0]        rd_flags,
  input  logic              rd_done,
  input  logic              rx_clear,
  output logic [PAGE_W-1:0] rx_pending,
  output logic              irq_rx,
  output logic              lost_flag,
  output logic [STAT_W-1:0] lost_cnt,
  output logic [STAT_W-1:0] err_cnt,
  input  logic              stat_clr
);
  localparam int PAGES = 1 << PAGE_W;
  localparam logic [PAGE_W:0] CNT_LIMIT = (PAGE_W+1)'(PAGES - 1);

  logic [PAGE_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PAGE_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PAGE_W-1:0] cnt_q, cnt_d;
  logic              lost_flag_q, lost_flag_d;
  logic [7:0]        flags_q [PAGES];

  logic            free;
  logic            room;
  logic            accept;
  logic            drop;
  logic [PAGE_W:0] cnt_after_free;

  // A release in the same cycle frees its slot before the new frame is judged.
  assign free           = !rx_clear && rd_done && (cnt_q != '0);
  assign cnt_after_free = {1'b0, cnt_q} - (PAGE_W+1)'(free);
  assign room           = cnt_after_free < CNT_LIMIT;
  assign accept         = !rx_clear && rx_switch && room;
  assign drop           = !rx_clear && rx_switch && !room;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    lost_flag_d = lost_flag_q;
    if (rx_clear) begin
      rd_ptr_d = wr_ptr_q;
      cnt_d    = '0;
    end else begin
      if (accept) wr_ptr_d = wr_ptr_q + PAGE_W'(1);
      if (free)   rd_ptr_d = rd_ptr_q + PAGE_W'(1);
      cnt_d = cnt_q + PAGE_W'(accept) - PAGE_W'(free);
    end
    if (stat_clr)  lost_flag_d = 1'b0;
    else if (drop) lost_flag_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      lost_flag_q <= 1'b0;
      for (int i = 0; i < PAGES; i++) flags_q[i] <= FLAG_OK;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      lost_flag_q <= lost_flag_d;
      if (accept) flags_q[wr_ptr_q] <= rx_flags;
    end
  end

  sat_cnt #(.W(STAT_W)) u_lost_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (drop),
    .clr     (stat_clr),
    .cnt     (lost_cnt)
  );

  sat_cnt #(.W(STAT_W)) u_err_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (rx_error),
    .clr     (stat_clr),
    .cnt     (err_cnt)
  );

  assign wr_page    = wr_ptr_q;
  assign rd_page    = rd_ptr_q;
  assign rd_flags   = flags_q[rd_ptr_q];
  assign rx_pending = cnt_q;
  assign irq_rx     = (cnt_q != '0);
  assign lost_flag  = lost_flag_q;
endmodule

// File: tb/tb_rx_page_ctrl.sv
// Directed bench for the page scheduler: a ping-pong instance and a four-page
// instance share stimulus; reset separates the phases that target each.
module tb_rx_page_ctrl;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx_switch, rx_error, rd_done, rx_clear, stat_clr;
  logic [7:0] rx_flags;

  logic [0:0] wr1, rd1, pend1;
  logic [7:0] rdf1, lost1, err1;
  logic       irq1, lflag1;
  logic [1:0] wr2, rd2, pend2;
  logic [7:0] rdf2, lost2, err2;
  logic       irq2, lflag2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rx_page_ctrl #(.PAGE_W(1)) u_pp (
    .clk(clk), .reset_n(reset_n), .rx_switch(rx_switch), .rx_flags(rx_flags),
    .rx_error(rx_error), .wr_page(wr1), .rd_page(rd1), .rd_flags(rdf1),
    .rd_done(rd_done), .rx_clear(rx_clear), .rx_pending(pend1), .irq_rx(irq1),
    .lost_flag(lflag1), .lost_cnt(lost1), .err_cnt(err1), .stat_clr(stat_clr)
  );

  rx_page_ctrl #(.PAGE_W(2)) u_q4 (
    .clk(clk), .reset_n(reset_n), .rx_switch(rx_switch), .rx_flags(rx_flags),
    .rx_error(rx_error), .wr_page(wr2), .rd_page(rd2), .rd_flags(rdf2),
    .rd_done(rd_done), .rx_clear(rx_clear), .rx_pending(pend2), .irq_rx(irq2),
    .lost_flag(lflag2), .lost_cnt(lost2), .err_cnt(err2), .stat_clr(stat_clr)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge, so each call spans exactly one rising edge.
  task automatic tick();
    @(negedge clk);
    rx_switch = 1'b0; rx_error = 1'b0; rd_done = 1'b0;
    rx_clear  = 1'b0; stat_clr = 1'b0; rx_flags = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] f);
    rx_switch = 1'b1; rx_flags = f;
    tick();
  endtask

  initial begin
    reset_n = 1'b0;
    rx_switch = 1'b0; rx_error = 1'b0; rd_done = 1'b0;
    rx_clear = 1'b0; stat_clr = 1'b0; rx_flags = 8'h00;
    do_reset();

    chk("rst_wr_page", wr1, 0);
    chk("rst_rd_page", rd1, 0);
    chk("rst_rd_flags", rdf1, 0);
    chk("rst_pending", pend1, 0);
    chk("rst_irq", irq1, 0);
    chk("rst_lost_flag", lflag1, 0);
    chk("rst_lost_cnt", lost1, 0);
    chk("rst_err_cnt", err1, 0);

    // Ping-pong: the second frame finds no free page and is dropped.
    push(8'h00);
    chk("pp1_wr_page", wr1, 1);
    chk("pp1_pending", pend1, 1);
    chk("pp1_irq", irq1, 1);
    chk("pp1_rd_page", rd1, 0);
    chk("pp1_rd_flags", rdf1, 8'h00);
    push(8'h23);
    chk("pp2_wr_page", wr1, 1);
    chk("pp2_lost_flag", lflag1, 1);
    chk("pp2_lost_cnt", lost1, 1);
    chk("pp2_pending", pend1, 1);
    chk("pp2_rd_flags", rdf1, 8'h00);
    stat_clr = 1'b1;
    tick();
    chk("pp_statclr_flag", lflag1, 0);
    chk("pp_statclr_cnt", lost1, 0);

    // Four pages: fill to three queued, then release and switch together.
    do_reset();
    push(8'h01);
    chk("q4_pend1", pend2, 1);
    push(8'h02);
    chk("q4_pend2", pend2, 2);
    push(8'h03);
    chk("q4_pend3", pend2, 3);
    chk("q4_wr3", wr2, 3);
    chk("q4_rdf0", rdf2, 8'h01);
    rd_done = 1'b1; rx_switch = 1'b1; rx_flags = 8'h04;
    tick();
    chk("q4_sim_pend", pend2, 3);
    chk("q4_sim_rd", rd2, 1);
    chk("q4_sim_rdf", rdf2, 8'h02);
    chk("q4_sim_wr", wr2, 0);
    chk("q4_sim_lost", lost2, 0);
    chk("q4_sim_lflag", lflag2, 0);

    // Drain, including one release on an empty queue.
    rd_done = 1'b1; tick();
    chk("dr1_pend", pend2, 2);
    chk("dr1_rd", rd2, 2);
    chk("dr1_rdf", rdf2, 8'h03);
    rd_done = 1'b1; tick();
    chk("dr2_pend", pend2, 1);
    chk("dr2_rdf", rdf2, 8'h04);
    rd_done = 1'b1; tick();
    chk("dr3_pend", pend2, 0);
    chk("dr3_irq", irq2, 0);
    chk("dr3_rd", rd2, 0);
    rd_done = 1'b1; tick();
    chk("dr4_pend", pend2, 0);
    chk("dr4_rd", rd2, 0);
    chk("dr4_wr", wr2, 0);

    // Clear wins over a coincident switch.
    push(8'h05);
    push(8'h06);
    chk("clr_pre_pend", pend2, 2);
    chk("clr_pre_wr", wr2, 2);
    rx_clear = 1'b1; rx_switch = 1'b1; rx_flags = 8'h07;
    tick();
    chk("clr_pend", pend2, 0);
    chk("clr_irq", irq2, 0);
    chk("clr_wr", wr2, 2);
    chk("clr_rd", rd2, 2);
    chk("clr_lost", lost2, 0);

    // Error statistics saturate and the clear beats a coincident increment.
    for (int i = 0; i < 10; i++) begin
      rx_error = 1'b1; tick();
    end
    chk("err_10", err2, 10);
    for (int i = 0; i < 290; i++) begin
      rx_error = 1'b1; tick();
    end
    chk("err_sat_q4", err2, 255);
    chk("err_sat_pp", err1, 255);
    stat_clr = 1'b1; rx_error = 1'b1;
    tick();
    chk("err_clr", err2, 0);
    rx_error = 1'b1; tick();
    chk("err_after_clr", err2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
